// File: rtl/alu_risc_pkg.sv
// alu_risc_pkg -- shared definitions for the sequential RISC ALU.
//   Opcode encodings (4-bit). RD/WR/BR/BRZ/BRO and the unused codes have no
//   entry here: they decode as NOP.
//   FSM state type for alu_seq_risc.
package alu_risc_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } alu_state_e;

endpackage

// File: rtl/mul_shift_add_risc.sv
// mul_shift_add_risc -- unsigned shift-add multiplier, one multiplier bit per
// clock. Operands are captured on start_i; done_o is asserted during the cycle
// whose closing edge performs the final iteration, and product_o then carries
// the completed 2*WORD_SIZE product (the accumulator's next value).
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    capture operands and begin (only honoured while idle by caller)
//   mcand_i    multiplicand
//   mplier_i   multiplier (scanned LSB first)
//   done_o     final-iteration strobe
//   product_o  product, valid while done_o is high
// Build option: ALU_SEQ_EARLY_TERM_EN stops as soon as the remaining shifted
// multiplier is zero (at least one iteration); otherwise WORD_SIZE iterations.
module mul_shift_add_risc #(
  parameter int WORD_SIZE = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [WORD_SIZE-1:0]   mcand_i,
  input  logic [WORD_SIZE-1:0]   mplier_i,
  output logic                   done_o,
  output logic [2*WORD_SIZE-1:0] product_o
);

  localparam int CNT_W = $clog2(WORD_SIZE);

  logic                   active_q;
  logic [2*WORD_SIZE-1:0] acc_q;
  logic [2*WORD_SIZE-1:0] acc_d;
  logic [2*WORD_SIZE-1:0] mcand_q;
  logic [WORD_SIZE-1:0]   mplier_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   last;

  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef ALU_SEQ_EARLY_TERM_EN
  // Bits above the one consumed this cycle are all zero: nothing left to add.
  assign last = (mplier_q[WORD_SIZE-1:1] == '0) ||
                (cnt_q == CNT_W'(WORD_SIZE - 1));
`else
  assign last = (cnt_q == CNT_W'(WORD_SIZE - 1));
`endif

  assign done_o    = active_q && last;
  assign product_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= {{WORD_SIZE{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      cnt_q    <= '0;
    end else if (active_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_risc.sv
// alu_seq_risc -- sequential RISC ALU. Single-cycle logic/arith ops and a
// multi-cycle unsigned MUL via mul_shift_add_risc.
//   clk            rising-edge clock
//   Reset_n        asynchronous active-low reset
//   start          one-cycle request; sel/data_1/data_2 sampled on that edge
//   sel            opcode
//   data_1,data_2  operands
//   busy           operation in progress (MUL_RUN or DONE); start ignored
//   done           one-cycle pulse, results valid
//   alu_out        result (MUL: low half)
//   mul_hi         MUL high half, 0 otherwise
//   zero_flag, overflow_flag, carry_flag  result flags
// Build option: ALU_SEQ_EARLY_TERM_EN (MUL early termination, latency only).
module alu_seq_risc
  import alu_risc_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic [OP_SIZE-1:0]   sel,
  input  logic [WORD_SIZE-1:0] data_1,
  input  logic [WORD_SIZE-1:0] data_2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] mul_hi,
  output logic                 zero_flag,
  output logic                 overflow_flag,
  output logic                 carry_flag
);

  alu_state_e state_q, state_d;

  logic                   is_mul;
  logic                   mul_start;
  logic                   mul_done;
  logic                   res_load;
  logic [2*WORD_SIZE-1:0] product;
  logic [WORD_SIZE:0]     sum_w;
  logic [WORD_SIZE-1:0]   diff;

  logic [WORD_SIZE-1:0] alu_out_q, alu_out_d;
  logic [WORD_SIZE-1:0] mul_hi_q, mul_hi_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 carry_q, carry_d;

  assign is_mul = (sel == OP_SIZE'(OP_MUL));
  assign sum_w  = {1'b0, data_1} + {1'b0, data_2};
  assign diff   = data_2 - data_1;

  mul_shift_add_risc #(
    .WORD_SIZE(WORD_SIZE)
  ) u_mul (
    .clk_i    (clk),
    .rst_ni   (Reset_n),
    .start_i  (mul_start),
    .mcand_i  (data_1),
    .mplier_i (data_2),
    .done_o   (mul_done),
    .product_o(product)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    res_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mul_start = is_mul;
          res_load  = !is_mul;
          state_d   = is_mul ? MUL_RUN : DONE;
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          res_load = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Non-MUL results are computed straight from the inputs on the start edge,
  // so the result registers double as the operand/opcode capture.
  always_comb begin
    alu_out_d = '0;
    mul_hi_d  = '0;
    zero_d    = 1'b0;
    ovf_d     = 1'b0;
    carry_d   = 1'b0;
    if (state_q == MUL_RUN) begin
      alu_out_d = product[WORD_SIZE-1:0];
      mul_hi_d  = product[2*WORD_SIZE-1:WORD_SIZE];
      zero_d    = (product == '0);
      ovf_d     = (product[2*WORD_SIZE-1:WORD_SIZE] != '0);
    end else begin
      case (sel)
        OP_SIZE'(OP_ADD): begin
          alu_out_d = sum_w[WORD_SIZE-1:0];
          carry_d   = sum_w[WORD_SIZE];
          ovf_d     = (data_1[WORD_SIZE-1] == data_2[WORD_SIZE-1]) &&
                      (sum_w[WORD_SIZE-1] != data_1[WORD_SIZE-1]);
        end
        OP_SIZE'(OP_SUB): begin
          alu_out_d = diff;
          carry_d   = (data_1 > data_2);
          ovf_d     = (data_1[WORD_SIZE-1] != data_2[WORD_SIZE-1]) &&
                      (diff[WORD_SIZE-1] != data_2[WORD_SIZE-1]);
        end
        OP_SIZE'(OP_AND): alu_out_d = data_1 & data_2;
        OP_SIZE'(OP_NOT): alu_out_d = ~data_2;
        OP_SIZE'(OP_OR):  alu_out_d = data_1 | data_2;
        OP_SIZE'(OP_XOR): alu_out_d = data_1 ^ data_2;
        default:          alu_out_d = '0;
      endcase
      zero_d = (alu_out_d == '0);
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      mul_hi_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_load) begin
        alu_out_q <= alu_out_d;
        mul_hi_q  <= mul_hi_d;
        zero_q    <= zero_d;
        ovf_q     <= ovf_d;
        carry_q   <= carry_d;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign alu_out       = alu_out_q;
  assign mul_hi        = mul_hi_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign carry_flag    = carry_q;

endmodule

// File: tb/tb_alu_seq_risc.sv
// tb_alu_seq_risc -- self-checking bench for alu_seq_risc (WORD_SIZE=8).
// Honours ALU_SEQ_EARLY_TERM_EN for expected MUL latency.
module tb_alu_seq_risc;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int MASK = FULL - 1;

  logic         clk     = 1'b0;
  logic         Reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [3:0]   sel     = '0;
  logic [W-1:0] data_1  = '0;
  logic [W-1:0] data_2  = '0;
  logic         busy, done, zero_flag, overflow_flag, carry_flag;
  logic [W-1:0] alu_out, mul_hi;

  always #5 clk = ~clk;

  alu_seq_risc #(
    .WORD_SIZE(W),
    .OP_SIZE  (4)
  ) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .sel          (sel),
    .data_1       (data_1),
    .data_2       (data_2),
    .busy         (busy),
    .done         (done),
    .alu_out      (alu_out),
    .mul_hi       (mul_hi),
    .zero_flag    (zero_flag),
    .overflow_flag(overflow_flag),
    .carry_flag   (carry_flag)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results, flags and latency from the arithmetic definitions.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int lo, output int hi, output int z,
                                 output int ov, output int cy, output int lat);
    int     sa, sb, r;
    longint p;
    sa = (a >= HALF) ? a - FULL : a;
    sb = (b >= HALF) ? b - FULL : b;
    lo = 0; hi = 0; ov = 0; cy = 0; lat = 1;
    case (op)
      1: begin
        r  = a + b;
        lo = r & MASK;
        cy = (r >= FULL) ? 1 : 0;
        ov = (sa + sb > HALF - 1 || sa + sb < -HALF) ? 1 : 0;
      end
      2: begin
        r  = b - a;
        lo = r & MASK;
        cy = (a > b) ? 1 : 0;
        ov = (sb - sa > HALF - 1 || sb - sa < -HALF) ? 1 : 0;
      end
      3:  lo = a & b;
      4:  lo = (~b) & MASK;
      10: begin
        p  = longint'(a) * longint'(b);
        lo = int'(p % FULL);
        hi = int'(p / FULL);
        ov = (hi != 0) ? 1 : 0;
`ifdef ALU_SEQ_EARLY_TERM_EN
        lat = 2;
        for (int i = 0; i < W; i++) if (((b >> i) & 1) == 1) lat = i + 2;
`else
        lat = W + 1;
`endif
      end
      11: lo = a | b;
      12: lo = a ^ b;
      default: lo = 0;
    endcase
    z = (lo == 0 && hi == 0) ? 1 : 0;
  endfunction

  // Model state: remaining cycles of the current operation and held results.
  int m_cnt = 0, m_done = 0, m_busy = 0, m_prev = 0;
  int m_lo = 0, m_hi = 0, m_z = 0, m_ov = 0, m_cy = 0;
  int p_lo, p_hi, p_z, p_ov, p_cy, p_lat;

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_cnt = 0; m_done = 0; m_busy = 0; m_prev = 0;
      m_lo = 0; m_hi = 0; m_z = 0; m_ov = 0; m_cy = 0;
    end else begin
      m_prev = m_done;
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_done = 1;
      end else if (start && m_prev == 0) begin
        ref_op(int'(sel), int'(data_1), int'(data_2), p_lo, p_hi, p_z, p_ov, p_cy, p_lat);
        m_cnt = p_lat - 1;
        if (m_cnt == 0) m_done = 1;
      end
      if (m_done == 1) begin
        m_lo = p_lo; m_hi = p_hi; m_z = p_z; m_ov = p_ov; m_cy = p_cy;
      end
      m_busy = (m_cnt > 0 || m_done == 1) ? 1 : 0;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_busy",    longint'(busy),          longint'(m_busy));
      check("cmp_done",    longint'(done),          longint'(m_done));
      check("cmp_alu_out", longint'(alu_out),       longint'(m_lo));
      check("cmp_mul_hi",  longint'(mul_hi),        longint'(m_hi));
      check("cmp_zero",    longint'(zero_flag),     longint'(m_z));
      check("cmp_ovf",     longint'(overflow_flag), longint'(m_ov));
      check("cmp_carry",   longint'(carry_flag),    longint'(m_cy));
    end
  end

  int cyc = 0;
  int ndone = 0;
  int last_done_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      last_done_cyc = cyc;
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int c0, output int n0);
    @(posedge clk); #1;
    sel = op; data_1 = a; data_2 = b; start = 1'b1;
    n0 = ndone;
    @(posedge clk); #1;
    c0 = cyc;
    start  = 1'b0;
    sel    = 4'($urandom);
    data_1 = W'($urandom);
    data_2 = W'($urandom);
  endtask

  task automatic wait_done(input int c0, input int n0, input int maxc, output int lat);
    lat = -1;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk);
      if (ndone != n0) break;
    end
    if (ndone != n0) lat = last_done_cyc - c0 + 1;
    #1;
  endtask

  task automatic check_res(input string tag, input int lo, input int hi,
                           input int z, input int ov, input int cy);
    check({tag, "_alu_out"}, longint'(alu_out),       longint'(lo));
    check({tag, "_mul_hi"},  longint'(mul_hi),        longint'(hi));
    check({tag, "_zero"},    longint'(zero_flag),     longint'(z));
    check({tag, "_ovf"},     longint'(overflow_flag), longint'(ov));
    check({tag, "_carry"},   longint'(carry_flag),    longint'(cy));
  endtask

  function automatic logic [W-1:0] rand_word();
    int r;
    r = int'($urandom_range(0, 7));
    case (r)
      0: return '0;
      1: return '1;
      2: return W'(HALF - 1);
      3: return W'(HALF);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int c0, n0, lat;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_res("rst", 0, 0, 0, 0, 0);
    check("rst_busy", longint'(busy), 0);
    Reset_n = 1'b1;

    start_op(4'b0001, 8'h7F, 8'h01, c0, n0);
    wait_done(c0, n0, 20, lat);
    check("add_lat", longint'(lat), 1);
    check_res("add7f01", 8'h80, 0, 0, 1, 0);

    start_op(4'b0010, 8'h05, 8'h05, c0, n0);
    wait_done(c0, n0, 20, lat);
    check("sub_lat", longint'(lat), 1);
    check_res("sub0505", 8'h00, 0, 1, 0, 0);

    start_op(4'b0010, 8'h06, 8'h05, c0, n0);
    wait_done(c0, n0, 20, lat);
    check_res("sub0605", 8'hFF, 0, 0, 0, 1);

    start_op(4'b1010, 8'hFF, 8'hFF, c0, n0);
    wait_done(c0, n0, 20, lat);
    check("mulff_lat", longint'(lat), 9);
    check_res("mulffff", 8'h01, 8'hFE, 0, 1, 0);

    start_op(4'b1010, 8'h03, 8'h02, c0, n0);
    wait_done(c0, n0, 20, lat);
`ifdef ALU_SEQ_EARLY_TERM_EN
    check("mul32_lat", longint'(lat), 3);
`else
    check("mul32_lat", longint'(lat), 9);
`endif
    check_res("mul0302", 8'h06, 8'h00, 0, 0, 0);

    // Second start arrives mid-MUL and must be dropped.
    start_op(4'b1010, 8'h10, 8'h10, c0, n0);
    @(posedge clk);
    @(posedge clk); #1;
    sel = 4'b0001; data_1 = 8'h11; data_2 = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("busy_ignore_ndone", longint'(ndone - n0), 1);
`ifdef ALU_SEQ_EARLY_TERM_EN
    check("busy_ignore_lat", longint'(last_done_cyc - c0 + 1), 6);
`else
    check("busy_ignore_lat", longint'(last_done_cyc - c0 + 1), 9);
`endif
    check_res("mul1010", 8'h00, 8'h01, 0, 1, 0);

    // Reset in the middle of a MUL.
    start_op(4'b1010, 8'hAB, 8'hCD, c0, n0);
    repeat (3) @(posedge clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check_res("midrst", 0, 0, 0, 0, 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    @(posedge clk); #1;
    Reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_nodone", longint'(ndone - n0), 0);
    start_op(4'b0001, 8'h01, 8'h01, c0, n0);
    wait_done(c0, n0, 20, lat);
    check("postrst_lat", longint'(lat), 1);
    check_res("postrst_add", 8'h02, 0, 0, 0, 0);

    // Randomized traffic; the compare process tracks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 2) == 0);
      sel    = ($urandom_range(0, 3) == 0) ? 4'b1010 : 4'($urandom);
      data_1 = rand_word();
      data_2 = rand_word();
      if ($urandom_range(0, 149) == 0) begin
        #2 Reset_n = 1'b0;
        #3 Reset_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_risc.md
ALU_SEQ_RISC -- requirements
Module: alu_seq_risc

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, operand/result width (legal range 4..32).
REQ-002 SHALL have parameter OP_SIZE, default 4, opcode width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request, samples sel/data_1/data_2.
REQ-006 SHALL have port sel  input  OP_SIZE  opcode.
REQ-007 SHALL have ports data_1, data_2  input  WORD_SIZE  operands.
REQ-008 SHALL have port busy  output  1  operation in progress, start ignored.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have ports alu_out, mul_hi  output  WORD_SIZE  result / MUL high half.
REQ-011 SHALL have ports zero_flag, overflow_flag, carry_flag  output  1  result flags.

Function
REQ-012 Opcodes: NOP 0000, ADD 0001, SUB 0010, AND 0011, NOT 0100, MUL 1010, OR 1011, XOR 1100; all others (RD/WR/BR/BRZ/BRO, unused) execute as NOP.
REQ-013 Results: ADD data_1+data_2; SUB data_2-data_1; AND/OR/XOR bitwise; NOT ~data_2; NOP 0; mul_hi 0 for all non-MUL ops.
REQ-014 Operands and opcode SHALL be registered on the start edge; later input changes do not affect the operation.
REQ-015 FSM states IDLE, MUL_RUN, DONE; IDLE->DONE on start with non-MUL op; IDLE->MUL_RUN on start with MUL; MUL_RUN->DONE after last iteration; DONE->IDLE unconditionally.
REQ-016 Non-MUL latency: done high exactly 1 cycle after the start edge.
REQ-017 MUL: unsigned sequential shift-add, one multiplier bit per cycle in sub-module, full 2*WORD_SIZE product; alu_out = low half, mul_hi = high half.
REQ-018 MUL latency (macro off): done high WORD_SIZE+1 cycles after the start edge.
REQ-019 busy SHALL be high in MUL_RUN and DONE; start while busy SHALL be ignored, no second done.
REQ-020 alu_out, mul_hi and flags SHALL update only on the done cycle and hold until the next done.
REQ-021 zero_flag = (alu_out==0) for non-MUL, (full product==0) for MUL.
REQ-022 overflow_flag: ADD signed overflow (equal operand signs, result sign differs); SUB signed overflow of data_2-data_1; MUL mul_hi!=0; else 0.
REQ-023 carry_flag: ADD carry-out; SUB borrow (data_1>data_2 unsigned); else 0.

Reset
REQ-024 Reset_n low SHALL immediately force IDLE, busy 0, done 0, alu_out 0, mul_hi 0, all flags 0, including mid-MUL; aborted MUL produces no done.

Configuration
REQ-025 Macro ALU_SEQ_EARLY_TERM_EN defined: MUL ends when remaining shifted multiplier is zero; iterations = max(1, index of data_2 MSB set + 1); latency = iterations+1.
REQ-026 Macro undefined: fixed WORD_SIZE iterations; results identical either way, only latency differs.

Structure
REQ-027 Package alu_risc_pkg SHALL hold opcode constants and FSM state typedef.
REQ-028 Sub-module mul_shift_add_risc (parametrised by WORD_SIZE, start/done handshake) SHALL hold the multiplier datapath and iteration counter.

Verification (WORD_SIZE=8)
REQ-029 ADD 7F,01 -> done 1 cycle later, alu_out 80, overflow 1, carry 0, zero 0.
REQ-030 SUB data_1=05, data_2=05 -> alu_out 00, zero 1, carry 0; SUB data_1=06, data_2=05 -> FF, carry 1.
REQ-031 MUL FF*FF, macro off -> done 9 cycles after start, mul_hi FE, alu_out 01, overflow 1.
REQ-032 MUL data_1=03, data_2=02, macro on -> done 3 cycles after start, alu_out 06, mul_hi 00, overflow 0.
REQ-033 start MUL 10*10, second start ADD at cycle 3 -> single done at cycle 9, mul_hi 01, alu_out 00.
REQ-034 Reset_n low at cycle 4 of MUL -> outputs 0 immediately, no done; ADD 01,01 afterwards -> alu_out 02.
